// File: rtl/int_to_float_pkg.sv
// Shared float-format helpers for the integer-to-float converter.
// Provides the exponent bias, the all-ones exponent code and the width of a leading-one index.
// Ports: none (package).
package int_to_float_pkg;

  // Bias of a float with an exp_w-bit exponent field. frac_w is part of the
  // format signature; a format with no fraction bits has no meaningful bias.
  function automatic int getExpBias(input int exp_w, input int frac_w);
    return (frac_w >= 1) ? (1 << (exp_w - 1)) - 1 : 0;
  endfunction

  // All-ones exponent code, reserved for infinity/NaN.
  function automatic int getMaxUnsignedExp(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Bits needed to hold a bit index of a width-bit word (ceil(log2(width))).
  function automatic int clog2Width(input int width);
    int r;
    r = 0;
    while ((1 << r) < width) r++;
    return r;
  endfunction

endpackage

// File: rtl/int_to_float_if.sv
// Stream bundle between an integer producer, the converter and a float consumer.
// Carries the input beat (integer + signedness) and the output beat (packed float + flags).
// Ports: master = producer/consumer side, slave = converter side.
interface int_to_float_if #(
  parameter int EXP   = 8,
  parameter int FRAC  = 23,
  parameter int WIDTH = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data;
  logic                in_signed;
  logic                out_valid;
  logic                out_ready;
  logic [EXP+FRAC:0]   out_data;
  logic                out_inexact;
  logic                out_overflow;

  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_inexact, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_inexact, out_overflow
  );
endinterface

// File: rtl/int_to_float_leading_one_detect.sv
// Leading-one detector: index of the most significant set bit of value.
// Latency 0 (combinational); no flow control.
// Ports: value (WIDTH) in; p (clog2(WIDTH)) out; zero out, high when value == 0 (p is then 0).
module leading_one_detect
  import int_to_float_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]              value,
  output logic [clog2Width(WIDTH)-1:0]  p,
  output logic                          zero
);
  localparam int PW = clog2Width(WIDTH);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) p = PW'(i);
    end
  end

  assign zero = ~|value;
endmodule

// File: rtl/int_to_float.sv
// Pipelined integer (signed/unsigned) to packed float converter, round-to-nearest-even.
// Latency 3 cycles from input transfer to out_valid; throughput 1 beat/cycle.
// Backpressure: each stage loads when empty or draining; ready chains combinationally from out_ready.
// Ports: clock, resetn (async, active-low); bus (slave): in_valid/in_ready/in_data/in_signed,
//        out_valid/out_ready/out_data {sign, exponent, fraction}/out_inexact/out_overflow.
module int_to_float
  import int_to_float_pkg::*;
#(
  parameter int EXP   = 8,
  parameter int FRAC  = 23,
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          resetn,
  int_to_float_if.slave bus
);
  localparam int PW      = clog2Width(WIDTH);
  localparam int EW      = ((EXP > PW) ? EXP : PW) + 2;
  localparam int BIAS    = getExpBias(EXP, FRAC);
  localparam int MAX_EXP = getMaxUnsignedExp(EXP);
  localparam int OW      = 1 + EXP + FRAC;
  // Bits below the hidden one, padded so frac, guard and sticky always exist.
  localparam int EXTW    = (WIDTH - 1) + FRAC + 2;

  typedef struct packed {
    logic             sign;
    logic [WIDTH-1:0] mag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic [PW-1:0]    p;
    logic [WIDTH-2:0] frac_bits;  // normalized magnitude without its leading one
  } s2_t;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          inexact;
    logic          overflow;
  } s3_t;

  logic s1_valid, s2_valid, s3_valid;
  s1_t  s1_q;
  s2_t  s2_q;
  s3_t  s3_q;

  // Load enables: a stage takes new contents when empty or when its
  // current contents move on this cycle.
  logic s1_load, s2_load, s3_load;
  assign s3_load = !s3_valid || bus.out_ready;
  assign s2_load = !s2_valid || s3_load;
  assign s1_load = !s1_valid || s2_load;

  assign bus.in_ready = s1_load;

  // ---------------- S1: sign and magnitude ----------------
  logic             in_sign;
  logic [WIDTH-1:0] in_mag;
  assign in_sign = bus.in_signed & bus.in_data[WIDTH-1];
  // The most negative value negates to itself, which read unsigned is its magnitude.
  assign in_mag  = in_sign ? (WIDTH'(0) - bus.in_data) : bus.in_data;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_q <= '{sign: in_sign, mag: in_mag};
    end
  end

  // ---------------- S2: normalize ----------------
  logic [PW-1:0]    lod_p;
  logic             lod_zero;
  logic [PW-1:0]    shamt;
  logic [WIDTH-2:0] norm_frac;

  leading_one_detect #(.WIDTH(WIDTH)) u_lod (
    .value (s1_q.mag),
    .p     (lod_p),
    .zero  (lod_zero)
  );

  assign shamt     = PW'(WIDTH - 1) - lod_p;
  // The shifted MSB is the hidden one; only the bits below it are kept.
  assign norm_frac = (WIDTH-1)'(s1_q.mag << shamt);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= '{sign: s1_q.sign, zero: lod_zero, p: lod_p, frac_bits: norm_frac};
    end
  end

  // ---------------- S3: round and pack ----------------
  logic [EXTW-1:0] ext;
  logic [FRAC-1:0] frac_top;
  logic            guard, sticky, round_up;
  logic [FRAC:0]   frac_sum;
  logic [EW-1:0]   exp_sum;
  s3_t             s3_d;

  assign ext      = {s2_q.frac_bits, {(FRAC + 2){1'b0}}};
  assign frac_top = ext[EXTW-1 -: FRAC];
  assign guard    = ext[EXTW-1-FRAC];
  assign sticky   = |ext[EXTW-2-FRAC:0];
  assign round_up = guard & (sticky | frac_top[0]);
  assign frac_sum = {1'b0, frac_top} + {{FRAC{1'b0}}, round_up};
  // A carry out of the fraction leaves it all zero and bumps the exponent.
  assign exp_sum  = EW'(s2_q.p) + EW'(BIAS) + {{(EW - 1){1'b0}}, frac_sum[FRAC]};

  // Layout {sign, exponent, fraction} matches the float datapath's Data word.
  always_comb begin
    s3_d = '0;
    if (s2_q.zero) begin
      s3_d = '0;  // +0 only, never -0
    end else if (exp_sum >= EW'(MAX_EXP)) begin
      s3_d.data     = {s2_q.sign, {EXP{1'b1}}, {FRAC{1'b0}}};
      s3_d.inexact  = 1'b1;
      s3_d.overflow = 1'b1;
    end else begin
      s3_d.data     = {s2_q.sign, exp_sum[EXP-1:0], frac_sum[FRAC-1:0]};
      s3_d.inexact  = guard | sticky;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s3_valid <= 1'b0;
      s3_q     <= '0;
    end else if (s3_load) begin
      s3_valid <= s2_valid;
      if (s2_valid) s3_q <= s3_d;
    end
  end

  assign bus.out_valid    = s3_valid;
  assign bus.out_data     = s3_q.data;
  assign bus.out_inexact  = s3_q.inexact;
  assign bus.out_overflow = s3_q.overflow;
endmodule

// File: tb/tb_int_to_float.sv
// Directed bench for int_to_float: single-precision and half-precision instances.
// Drives on the falling edge, samples outputs after the falling edge.
// Ports: none (top-level bench).
module tb_int_to_float;
  logic clock;
  logic resetn;
  int   tests = 0;
  int   fails = 0;

  int_to_float_if #(.EXP(8), .FRAC(23), .WIDTH(32)) a ();
  int_to_float_if #(.EXP(5), .FRAC(10), .WIDTH(32)) b ();

  int_to_float #(.EXP(8), .FRAC(23), .WIDTH(32)) dut_a (
    .clock (clock), .resetn (resetn), .bus (a)
  );
  int_to_float #(.EXP(5), .FRAC(10), .WIDTH(32)) dut_b (
    .clock (clock), .resetn (resetn), .bus (b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
    $fatal(1);
  end

  // Real-valued reference: exact int -> double, then RNE of the double mantissa to 23 bits.
  function automatic void ref_f32(input logic [31:0] d, input logic s,
                                  output logic [31:0] f, output logic inx);
    longint      v;
    real         r;
    logic [63:0] bits;
    logic [51:0] m;
    logic [23:0] fr;
    logic        g, st;
    int          e;
    v = s ? longint'($signed(d)) : longint'({32'b0, d});
    if (v == 0) begin
      f = '0;
      inx = 1'b0;
      return;
    end
    r    = real'(v);
    bits = $realtobits(r);
    m    = bits[51:0];
    g    = m[28];
    st   = |m[27:0];
    fr   = {1'b0, m[51:29]} + ((g && (st || m[29])) ? 24'd1 : 24'd0);
    e    = int'(bits[62:52]) - 1023 + 127 + int'(fr[23]);
    f    = {bits[63], 8'(e), fr[22:0]};
    inx  = g | st;
  endfunction

  // Drive one beat into instance a and collect its result; lat counts edges from transfer.
  task automatic conv_a(input logic [31:0] d, input logic s,
                        output logic [31:0] od, output logic [1:0] ofl, output int lat);
    logic done;
    done = 1'b0; od = '0; ofl = '0;
    @(negedge clock);
    a.in_valid = 1'b1; a.in_data = d; a.in_signed = s; a.out_ready = 1'b1;
    @(posedge clock); #1;
    a.in_valid = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clock);
      if (a.out_valid) begin
        done = 1'b1; od = a.out_data; ofl = {a.out_inexact, a.out_overflow};
      end else begin
        @(posedge clock); lat++;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic conv_b(input logic [31:0] d, input logic s,
                        output logic [15:0] od, output logic [1:0] ofl, output int lat);
    logic done;
    done = 1'b0; od = '0; ofl = '0;
    @(negedge clock);
    b.in_valid = 1'b1; b.in_data = d; b.in_signed = s; b.out_ready = 1'b1;
    @(posedge clock); #1;
    b.in_valid = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clock);
      if (b.out_valid) begin
        done = 1'b1; od = b.out_data; ofl = {b.out_inexact, b.out_overflow};
      end else begin
        @(posedge clock); lat++;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (a.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid: got %b expected 0", a.out_valid);
    end
    tests++;
    if (a.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b expected 1", a.in_ready);
    end
    tests++;
    if ({a.out_data, a.out_inexact, a.out_overflow} !== 34'd0) begin
      fails++;
      $display("FAIL reset_out_regs: got %h/%b%b expected 0", a.out_data, a.out_inexact, a.out_overflow);
    end
    #10 resetn = 1'b1;
    @(negedge clock);
    tests++;
    if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_idle: got valid=%b ready=%b expected valid=0 ready=1", a.out_valid, a.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vin [3];
    logic        vsg [3];
    logic [31:0] vexp [3];
    int n;
    vin  = '{32'd0, 32'd1, 32'hFFFF_FFFF};
    vsg  = '{1'b0, 1'b0, 1'b1};
    vexp = '{32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000};
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      a.out_ready = 1'b1;
      a.in_valid  = (c < 3);
      if (c < 3) begin
        a.in_data = vin[c]; a.in_signed = vsg[c];
      end
      #1;
      if (a.out_valid && n < 3) begin
        tests++;
        if (a.out_data !== vexp[n]) begin
          fails++; $display("FAIL b2b_data[%0d]: got %h expected %h", n, a.out_data, vexp[n]);
        end
        tests++;
        if ({a.out_inexact, a.out_overflow} !== 2'b00) begin
          fails++; $display("FAIL b2b_flags[%0d]: got %b%b expected 00", n, a.out_inexact, a.out_overflow);
        end
        tests++;
        if (c !== 3 + n) begin
          fails++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", n, c, 3 + n);
        end
        n++;
      end
    end
    a.in_valid = 1'b0;
    tests++;
    if (n !== 3) begin
      fails++; $display("FAIL b2b_count: got %0d expected 3", n);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] vin [4];
    logic        vsg [4];
    logic [31:0] vexp [4];
    logic [1:0]  vfl [4];
    logic [31:0] od;
    logic [1:0]  ofl;
    int          lat;
    vin  = '{32'd16777217, 32'd16777219, 32'hFFFF_FFFF, 32'h8000_0000};
    vsg  = '{1'b0, 1'b0, 1'b0, 1'b1};
    vexp = '{32'h4B80_0000, 32'h4B80_0002, 32'h4F80_0000, 32'hCF00_0000};
    vfl  = '{2'b10, 2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      conv_a(vin[i], vsg[i], od, ofl, lat);
      tests++;
      if (od !== vexp[i]) begin
        fails++; $display("FAIL round_data[%0d]: got %h expected %h", i, od, vexp[i]);
      end
      tests++;
      if (ofl !== vfl[i]) begin
        fails++; $display("FAIL round_flags[%0d]: got %b expected %b", i, ofl, vfl[i]);
      end
      tests++;
      if (lat !== 3) begin
        fails++; $display("FAIL round_latency[%0d]: got %0d expected 3", i, lat);
      end
    end
  endtask

  task automatic test_half_precision();
    logic [31:0] vin [3];
    logic        vsg [3];
    logic [15:0] vexp [3];
    logic [1:0]  vfl [3];
    logic [15:0] od;
    logic [1:0]  ofl;
    int          lat;
    vin  = '{32'd65504, 32'd65520, 32'hFFFE_EE90};
    vsg  = '{1'b0, 1'b0, 1'b1};
    vexp = '{16'h7BFF, 16'h7C00, 16'hFC00};
    vfl  = '{2'b00, 2'b11, 2'b11};
    for (int i = 0; i < 3; i++) begin
      conv_b(vin[i], vsg[i], od, ofl, lat);
      tests++;
      if (od !== vexp[i]) begin
        fails++; $display("FAIL half_data[%0d]: got %h expected %h", i, od, vexp[i]);
      end
      tests++;
      if (ofl !== vfl[i]) begin
        fails++; $display("FAIL half_flags[%0d]: got %b expected %b", i, ofl, vfl[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] vd [10];
    logic        vs [10];
    logic [31:0] ed [10];
    logic        ei [10];
    int sent, recv, full_seen, extra;
    for (int i = 0; i < 10; i++) begin
      vd[i] = $urandom;
      vs[i] = 1'($urandom_range(0, 1));
      ref_f32(vd[i], vs[i], ed[i], ei[i]);
    end
    sent = 0; recv = 0; full_seen = 0;
    for (int c = 0; c < 60 && recv < 10; c++) begin
      @(negedge clock);
      a.out_ready = !(c >= 4 && c < 9);
      a.in_valid  = (sent < 10);
      if (sent < 10) begin
        a.in_data = vd[sent]; a.in_signed = vs[sent];
      end
      #1;
      if (!a.in_ready) begin
        full_seen++;
        tests++;
        if (sent - recv !== 3) begin
          fails++; $display("FAIL bp_occupancy: got %0d held beats expected 3 at cycle %0d", sent - recv, c);
        end
      end
      if (a.out_valid && a.out_ready) begin
        tests++;
        if ({a.out_data, a.out_inexact, a.out_overflow} !== {ed[recv], ei[recv], 1'b0}) begin
          fails++;
          $display("FAIL bp_beat[%0d]: got %h/%b%b expected %h/%b0", recv,
                   a.out_data, a.out_inexact, a.out_overflow, ed[recv], ei[recv]);
        end
        recv++;
      end
      if (a.in_valid && a.in_ready) sent++;
    end
    @(posedge clock); #1;
    a.in_valid = 1'b0; a.out_ready = 1'b1;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (a.out_valid) extra++;
    end
    tests++;
    if (recv !== 10 || sent !== 10) begin
      fails++; $display("FAIL bp_count: got sent=%0d recv=%0d expected 10/10", sent, recv);
    end
    tests++;
    if (extra !== 0) begin
      fails++; $display("FAIL bp_duplicates: got %0d extra beats expected 0", extra);
    end
    tests++;
    if (full_seen === 0) begin
      fails++; $display("FAIL bp_in_ready_low: got 0 cycles with in_ready low expected >0");
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] od;
    logic [1:0]  ofl;
    int          lat, stale;
    a.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      a.in_valid = 1'b1; a.in_data = 32'(5 + c); a.in_signed = 1'b0;
    end
    @(posedge clock); #1;
    a.in_valid = 1'b0;
    tests++;
    if (a.out_valid !== 1'b1) begin
      fails++; $display("FAIL rst_precondition_valid: got %b expected 1", a.out_valid);
    end
    #1 resetn = 1'b0;
    #1;
    tests++;
    if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_async: got valid=%b ready=%b expected valid=0 ready=1", a.out_valid, a.in_ready);
    end
    tests++;
    if (a.out_data !== 32'd0) begin
      fails++; $display("FAIL rst_async_data: got %h expected 00000000", a.out_data);
    end
    @(negedge clock); #1;
    resetn = 1'b1;
    stale = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (a.out_valid) stale++;
    end
    tests++;
    if (stale !== 0) begin
      fails++; $display("FAIL rst_discard: got %0d stale beats expected 0", stale);
    end
    conv_a(32'd2, 1'b0, od, ofl, lat);
    tests++;
    if (od !== 32'h4000_0000 || ofl !== 2'b00) begin
      fails++; $display("FAIL rst_new_beat: got %h/%b expected 40000000/00", od, ofl);
    end
    tests++;
    if (lat !== 3) begin
      fails++; $display("FAIL rst_new_latency: got %0d expected 3", lat);
    end
  endtask

  initial begin
    resetn      = 1'b0;
    a.in_valid  = 1'b0; a.in_data = '0; a.in_signed = 1'b0; a.out_ready = 1'b0;
    b.in_valid  = 1'b0; b.in_data = '0; b.in_signed = 1'b0; b.out_ready = 1'b1;
    test_reset();
    test_back_to_back();
    test_rounding();
    test_half_precision();
    test_backpressure();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/int_to_float.md
# int_to_float

Pipelined converter from a WIDTH-bit integer, signed or unsigned, to a packed IEEE-style float of parameterized EXP/FRAC. Rounding is round-to-nearest-even. It is the encoding counterpart to the Float interface's decode helpers (sign/exponent/fraction classification, signed exponent). It feeds integer accumulator results and host-supplied constants into the float datapath through valid/ready streams.

## Interface
- EXP, 8, exponent field width; must be ≥ 2.
- FRAC, 23, fraction field width; must be ≥ 1.
- WIDTH, 32, integer input width; must be ≥ 2.
- clock  in  1  sole clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  converter can accept a beat this cycle.
- in_data  in  WIDTH  integer operand.
- in_signed  in  1  1: in_data is two's complement; 0: in_data is unsigned.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  1+EXP+FRAC  packed {sign, exponent, fraction}.
- out_inexact  out  1  rounding discarded nonzero bits.
- out_overflow  out  1  result rounded to infinity.

## Operation
- Beat transfer: a beat transfers on a clock edge where valid && ready. in_data and in_signed are sampled only on input transfer.
- Stage 1 (S1), magnitude:
  - sign = in_signed & in_data[WIDTH-1].
  - mag = sign ? −in_data : in_data, held WIDTH bits unsigned. −2^(WIDTH−1) yields mag = 2^(WIDTH−1), which is correct.
- Stage 2 (S2), normalize:
  - p = index of the leading one of mag.
  - norm = mag << (WIDTH−1−p), so the MSB is 1.
  - zero flag = (mag == 0).
- Stage 3 (S3), round and pack:
  - frac = norm[WIDTH−2 -: FRAC], zero-padded on the right when WIDTH−1 < FRAC.
  - guard = next bit below frac. sticky = OR of all remaining bits.
  - Round up iff guard && (sticky || frac[0]).
  - Biased exponent = p + bias, with bias = 2^(EXP−1)−1, computed at width max(EXP, clog2(WIDTH))+2.
  - A fraction carry-out clears frac and increments the exponent.
  - If the exponent ≥ 2^EXP−1: output ±inf, out_overflow=1, out_inexact=1.
  - out_inexact = guard|sticky otherwise.
- Zero input: out_data = +0, flags 0. Negative zero is never produced.
- Subnormal results are impossible (|x| ≥ 1), and NaN is never produced.

## Timing
- Latency is 3 cycles from input transfer to out_valid, when there is no backpressure.
- Throughput is 1 beat per cycle.
- Each stage has a valid bit. A stage loads when it is empty or its contents advance this cycle.
  - in_ready = !s1_valid || s1_advance.
  - s3 advances on out_ready.
  - The ready chain is combinational back to out_ready.
- With out_ready low, the pipeline fills. in_ready falls after 3 beats are held, and no beat is lost or duplicated.
- out_data and the flags are stable while out_valid && !out_ready.
- Reset: all stage valid bits clear immediately and asynchronously. Beats in flight are discarded.
  - out_valid=0, in_ready=1 after reset.
  - out_data and flags reset to 0.
- Simultaneous input transfer and output transfer on a full pipeline: legal. Occupancy stays 3.

## Structure
- Shared package FloatDef holds:
  - getExpBias(EXP, FRAC), reused.
  - getMaxUnsignedExp, reused.
  - New function clog2Width for the internal exponent width.
- Sub-module leading_one_detect (parameter WIDTH): combinational, outputs p and zero. Instantiated in S2.
- out_data is assembled as Float#(EXP, FRAC)::Data layout so callers can drive a Float.OutputIf directly.

## Test plan
- Defaults, unsigned 0, 1, and signed −1 back-to-back → 0x00000000, 0x3F800000, 0xBF800000; flags 0; out_valid on cycles 3, 4, 5.
- 16777217 (tie, even) → 0x4B800000 inexact=1. 16777219 (tie, odd) → 0x4B800002 inexact=1.
- Unsigned 0xFFFFFFFF → 0x4F800000 inexact=1. Signed 0x80000000 → 0xCF000000 inexact=0.
- EXP=5, FRAC=10: 65504 → 0x7BFF flags 0. 65520 → 0x7C00 overflow=1 inexact=1. Signed −70000 → 0xFC00 overflow=1.
- Backpressure: stream 10 random beats with out_ready low for 5 cycles mid-stream.
  - in_ready deasserts after 3 held beats.
  - The output sequence matches a real-valued reference model.
  - No drops or duplicates.
- Assert resetn low while 3 beats are in flight → out_valid=0 immediately. After release, a new beat 2 → 0x40000000 at latency 3.
